// File: rtl/cpu32_trace_buffer.sv
// cpu32_trace_buffer: circular FIFO capturing one CPU32 observation-bus entry per
// traced cycle. Each entry is tagged with a 16-bit sequence number, and entries
// lost to overflow are counted.
// Read port is first-word fall-through with valid/ready.
// Optional build macro CPU32_TRACE_MEMWR_FILTER_EN: store only data-memory writes.
module cpu32_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              trace_en,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       immediate,
    input  logic              DataMemRW,
    input  logic [31:0]       result,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [69:0]       rd_data,
    output logic [15:0]       rd_seq,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned ENTRY_W = 70;
    localparam int unsigned SEQ_W   = 16;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] immediate;
        logic        dataMemRw;
        logic [31:0] result;
    } traceEntry_t;

    logic [ENTRY_W-1:0] entryMem [DEPTH];
    logic [SEQ_W-1:0]   seqMem   [DEPTH];

    logic [ADDR_W-1:0]  wrPtr;
    logic [ADDR_W-1:0]  rdPtr;
    logic [SEQ_W-1:0]   seqCnt;

    traceEntry_t wrEntry;
    logic        candidate;
    logic        storeReq;
    logic        push;
    logic        pop;
    logic        drop;

    // Candidate qualification, push/pop/drop decisions and read-port view.
    always_comb begin
        wrEntry   = '0;
        candidate = 1'b0;
        storeReq  = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        rd_valid  = 1'b0;
        full      = 1'b0;
        rd_data   = '0;
        rd_seq    = '0;

        wrEntry.op        = op;
        wrEntry.rs        = rs;
        wrEntry.rt        = rt;
        wrEntry.rd        = rd;
        wrEntry.immediate = immediate;
        wrEntry.dataMemRw = DataMemRW;
        wrEntry.result    = result;

        rd_valid  = (count != '0);
        full      = (count == DEPTH_CNT);
        candidate = trace_en && !Reset;
`ifdef CPU32_TRACE_MEMWR_FILTER_EN
        storeReq  = candidate && DataMemRW;
`else
        storeReq  = candidate;
`endif
        // rd_valid is false when empty, so a fresh write is never popped the same cycle.
        pop       = rd_valid && rd_ready && !Reset;
        push      = storeReq && (!full || pop);
        drop      = storeReq && full && !pop;

        if (rd_valid) begin
            rd_data = entryMem[rdPtr];
            rd_seq  = seqMem[rdPtr];
        end
    end

    // Entry storage; deliberately not cleared by reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            entryMem[wrPtr] <= wrEntry;
            seqMem[wrPtr]   <= seqCnt;
        end
    end

    // Pointers, occupancy, sequence and drop counters.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            seqCnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (candidate) begin
                seqCnt <= seqCnt + SEQ_W'(1);
            end
            if (push) begin
                wrPtr <= wrPtr + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/cpu32_trace_buffer.md
Name: cpu32_trace_buffer

Overview:
- Sink for the CPU32 per-cycle observation bus (op, rs, rt, rd, immediate, result, DataMemRW).
- Captures one entry per clock while tracing is enabled, since the single-cycle core retires one instruction per CLK.
- Entries are buffered in a circular FIFO and drained through a valid/ready read port by a debug host or bench scoreboard.
- Counts entries lost to overflow and tags every entry with a sequence number, so gaps are visible.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- trace_en  in  1  capture enable; each high cycle is one candidate retirement.
- op  in  6  CPU opcode.
- rs  in  5  source register 1.
- rt  in  5  source register 2.
- rd  in  5  destination register.
- immediate  in  16  instruction immediate.
- DataMemRW  in  1  data-memory write strobe of the retired instruction.
- result  in  32  ALU result of the retired instruction.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  70  head entry, packed as {op, rs, rt, rd, immediate, DataMemRW, result}, op in the MSBs.
- rd_seq  out  16  sequence number of the head entry.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- drop_cnt  out  16  number of entries lost to overflow.

Behaviour:
- Reset (synchronous, active-high, Reset=1 at a CLK edge):
  - wr_ptr=0, rd_ptr=0, count=0, seq counter=0, drop_cnt=0.
  - Outputs: rd_valid=0, full=0, rd_data=0 and rd_seq=0 while empty.
  - Storage contents are not cleared.
  - Reset overrides everything in the same cycle, including a push and a pop; any pending entries are discarded.
- Candidate and push:
  - Candidate cycle: trace_en=1 and Reset=0.
  - Every candidate increments the seq counter by 1 (16-bit, wraps 0xFFFF->0x0000), whether or not the entry is stored.
  - Push = candidate AND (not full OR pop in the same cycle).
  - A push writes the bus fields and the current seq value (before its increment) at wr_ptr; wr_ptr advances mod DEPTH.
- Pop and read port:
  - Pop = rd_valid AND rd_ready; rd_ptr advances mod DEPTH.
  - rd_valid = (count != 0).
  - rd_data and rd_seq are combinational from the head entry (first-word fall-through). They are 0 when empty.
  - Head data is held stable while rd_valid=1 and rd_ready=0.
- Latency: an entry captured at edge N is visible on rd_valid/rd_data after edge N. A write to an empty FIFO is never popped in that same cycle.
- Occupancy update: count += push - pop.
  - Simultaneous push and pop while full: both are accepted, count stays DEPTH, nothing is dropped.
  - Simultaneous push and pop at count=1: both are accepted, count stays 1, and the new entry becomes head.
- Overflow:
  - A candidate while full with no pop is dropped; storage and pointers are unchanged.
  - drop_cnt increments by 1 per dropped entry and saturates at 0xFFFF.
- Pointers wrap silently; full and empty are decided by count, not by pointer compare.
- rd_ready while empty has no effect.

Optional Feature:
- Macro: CPU32_TRACE_MEMWR_FILTER_EN.
- Defined:
  - A candidate is stored only if DataMemRW=1.
  - Candidates with DataMemRW=0 still increment the seq counter.
  - They are neither stored nor counted in drop_cnt.
- Undefined: every candidate is stored, subject to the overflow rules above.

Test Plan:
1. Reset, then trace_en=1 for 3 cycles with result=0x11,0x22,0x33 and rd_ready=0 -> count=3; rd_valid=1; head result=0x11 with rd_seq=0. Raising rd_ready then drains 0x11,0x22,0x33 with seq 0,1,2 on consecutive cycles, then rd_valid=0.
2. rd_ready=0 and 20 consecutive candidates with DEPTH=16 -> full=1, count=16, drop_cnt=4. Drain yields seq 0..15 in order.
3. FIFO full with rd_ready=1 and trace_en=1 for 5 cycles -> count stays 16 and drop_cnt does not change. Entries read out in seq order with no gap.
4. Run 18 candidates pop-as-you-go (pointers wrap past 15) -> rd_seq sequence 0..17 contiguous; rd_data fields match the driven op/rs/rt/rd/immediate exactly.
5. Reset asserted at count=7 together with rd_ready=1 and trace_en=1 -> next cycle count=0, rd_valid=0, drop_cnt=0. The first subsequent entry has seq 0.
6. CPU32_TRACE_MEMWR_FILTER_EN defined; 6 candidates with DataMemRW=0,1,0,1,1,0 -> 3 entries stored with rd_seq 1,3,4; drop_cnt=0.
